// File: rtl/alu_if.sv
// alu_if.sv - shared ALU definitions and the ALU operand/result bundle.
//
// common_pkg carries the datapath width and the ALU_ctrl_t operation
// encoding used by the execute stage. The ALU_EXT_OPS_EN macro selects
// whether the ALU implements the extended encodings.
//
// alu_if groups the operand/control inputs and the registered results:
//   ALU_ctrl   operation select (ALU_ctrl_t)
//   data_in_A  operand A
//   data_in_B  operand B
//   valid_in   operands and control valid this cycle
//   data_out   registered result
//   zero       registered, high when data_out == 0
//   overflow   registered signed overflow for ADD/SUB
//   valid_out  valid_in delayed by one cycle
// The master modport drives operands; the slave modport is the ALU itself.

package common_pkg;

  parameter int RISC_V_DATA_WIDTH = 64;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_NOR  = 4'b1100,
    ALU_SRA  = 4'b1101
  } ALU_ctrl_t;

endpackage

interface alu_if;
  import common_pkg::*;

  ALU_ctrl_t                    ALU_ctrl;
  logic [RISC_V_DATA_WIDTH-1:0] data_in_A;
  logic [RISC_V_DATA_WIDTH-1:0] data_in_B;
  logic                         valid_in;
  logic [RISC_V_DATA_WIDTH-1:0] data_out;
  logic                         zero;
  logic                         overflow;
  logic                         valid_out;

  modport master (
    output ALU_ctrl, data_in_A, data_in_B, valid_in,
    input  data_out, zero, overflow, valid_out
  );

  modport slave (
    input  ALU_ctrl, data_in_A, data_in_B, valid_in,
    output data_out, zero, overflow, valid_out
  );

endinterface

// File: rtl/alu.sv
// alu.sv - registered integer ALU for the execute stage.
//
// Computes AND/OR/ADD/SUB (and, when ALU_EXT_OPS_EN is defined, XOR, SLL,
// SRL, SRA, SLT, SLTU, NOR) from two operands every cycle. Result, zero
// flag and signed overflow are registered, giving a one-cycle latency and
// one operation per cycle. valid_in only qualifies valid_out.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  alu_if.slave (operands, control, registered results)
//
// Configuration macro: ALU_EXT_OPS_EN (undefined -> base ops only; the
// extended codes then fall into the default case and give result 0).

module alu
  import common_pkg::*;
(
  input logic   clk,
  input logic   rst,
  alu_if.slave  bus
);

  localparam int W = RISC_V_DATA_WIDTH;

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] result;
  logic         ovf;

`ifdef ALU_EXT_OPS_EN
  logic [5:0] shamt;
  assign shamt = bus.data_in_B[5:0];
`endif

  assign sum  = bus.data_in_A + bus.data_in_B;
  assign diff = bus.data_in_A - bus.data_in_B;

  // Overflow is judged from operand and result sign bits only; every
  // non-arithmetic code leaves it low.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (bus.ALU_ctrl)
      ALU_AND: result = bus.data_in_A & bus.data_in_B;
      ALU_OR:  result = bus.data_in_A | bus.data_in_B;
      ALU_ADD: begin
        result = sum;
        ovf    = (bus.data_in_A[W-1] == bus.data_in_B[W-1]) &&
                 (sum[W-1] != bus.data_in_A[W-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (bus.data_in_A[W-1] != bus.data_in_B[W-1]) &&
                 (diff[W-1] != bus.data_in_A[W-1]);
      end
`ifdef ALU_EXT_OPS_EN
      ALU_XOR:  result = bus.data_in_A ^ bus.data_in_B;
      ALU_SLL:  result = bus.data_in_A << shamt;
      ALU_SRL:  result = bus.data_in_A >> shamt;
      ALU_SRA:  result = W'($signed(bus.data_in_A) >>> shamt);
      ALU_SLT:  result = {{(W-1){1'b0}},
                          ($signed(bus.data_in_A) < $signed(bus.data_in_B))};
      ALU_SLTU: result = {{(W-1){1'b0}}, (bus.data_in_A < bus.data_in_B)};
      ALU_NOR:  result = ~(bus.data_in_A | bus.data_in_B);
`endif
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

  // Output register stage; reset wins over any operation presented on the
  // same edge, leaving a zero result with the zero flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out  <= '0;
      bus.zero      <= 1'b1;
      bus.overflow  <= 1'b0;
      bus.valid_out <= 1'b0;
    end else begin
      bus.data_out  <= result;
      bus.zero      <= (result == '0);
      bus.overflow  <= ovf;
      bus.valid_out <= bus.valid_in;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu.sv - self-checking bench for the registered ALU.
//
// Inputs change on the falling edge; outputs are sampled on the falling
// edge one rising edge later. Expected values come from constants and a
// behavioural model written with plain arithmetic. ALU_EXT_OPS_EN selects
// which model and directed vectors apply.

module tb_alu;
  import common_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  alu_if alu_bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (alu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic signed [64:0] MAX_S = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] MIN_S = -65'sh0_8000_0000_0000_0000;

  // Behavioural reference: the mathematical meaning of each code.
  function automatic void model(input logic [3:0] op, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] r,
                                output logic ov);
    logic signed [64:0] wide;
    int n;
    n  = int'(b[5:0]);
    r  = 64'd0;
    ov = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        wide = $signed({a[63], a}) + $signed({b[63], b});
        r    = wide[63:0];
        ov   = (wide > MAX_S) || (wide < MIN_S);
      end
      4'b0110: begin
        wide = $signed({a[63], a}) - $signed({b[63], b});
        r    = wide[63:0];
        ov   = (wide > MAX_S) || (wide < MIN_S);
      end
`ifdef ALU_EXT_OPS_EN
      4'b0011: r = a ^ b;
      4'b0100: r = a << n;
      4'b0101: r = a >> n;
      4'b1101: begin
        r = a;
        for (int k = 0; k < n; k++) r = {r[63], r[63:1]};
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b1000: r = (a < b) ? 64'd1 : 64'd0;
      4'b1100: r = ~(a | b);
`endif
      default: r = 64'd0;
    endcase
  endfunction

  // Drive one operation on the falling edge.
  task automatic drive(input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic v);
    alu_bus.ALU_ctrl  = ALU_ctrl_t'(op);
    alu_bus.data_in_A = a;
    alu_bus.data_in_B = b;
    alu_bus.valid_in  = v;
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] edges [6];
    edges[0] = 64'd0;
    edges[1] = 64'd1;
    edges[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    edges[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    edges[4] = 64'h8000_0000_0000_0000;
    edges[5] = 64'd64;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0010, 64'd1, 64'd1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (alu_bus.data_out !== 64'd0)
      $display("[TB] FAIL reset_data_out got=%h want=%h", alu_bus.data_out, 64'd0);
    else passes++;
    checks++;
    if (alu_bus.zero !== 1'b1)
      $display("[TB] FAIL reset_zero got=%b want=1", alu_bus.zero);
    else passes++;
    checks++;
    if (alu_bus.overflow !== 1'b0)
      $display("[TB] FAIL reset_overflow got=%b want=0", alu_bus.overflow);
    else passes++;
    checks++;
    if (alu_bus.valid_out !== 1'b0)
      $display("[TB] FAIL reset_valid_out got=%b want=0", alu_bus.valid_out);
    else passes++;
    rst = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        ov;
  } vec_t;

  task automatic test_directed();
    vec_t v [$];
    v.push_back('{"and",     4'b0000, 64'd223,     64'd132,    64'd132,    1'b0});
    v.push_back('{"or",      4'b0001, 64'd4013,    64'd3022,   64'd4079,   1'b0});
    v.push_back('{"add",     4'b0010, 64'd5555,    64'd4321,   64'd9876,   1'b0});
    v.push_back('{"sub",     4'b0110, 64'd999999,  64'd111111, 64'd888888, 1'b0});
    v.push_back('{"sub_eq",  4'b0110, 64'd7,       64'd7,      64'd0,      1'b0});
    v.push_back('{"add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                  64'h8000_0000_0000_0000, 1'b1});
`ifdef ALU_EXT_OPS_EN
    v.push_back('{"sra",     4'b1101, 64'h8000_0000_0000_0000, 64'd4,
                  64'hF800_0000_0000_0000, 1'b0});
    v.push_back('{"slt",     4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0});
    v.push_back('{"sltu",    4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0});
    v.push_back('{"sll_65",  4'b0100, 64'd3,       64'd65,     64'd6,      1'b0});
`else
    v.push_back('{"xor_off", 4'b0011, 64'd5,       64'd3,      64'd0,      1'b0});
`endif
    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i].op, v[i].a, v[i].b, 1'b1);
      @(negedge clk);
      checks++;
      if (alu_bus.data_out !== v[i].res)
        $display("[TB] FAIL %s_data got=%h want=%h", v[i].name, alu_bus.data_out, v[i].res);
      else passes++;
      checks++;
      if (alu_bus.zero !== (v[i].res == 64'd0))
        $display("[TB] FAIL %s_zero got=%b want=%b", v[i].name, alu_bus.zero, (v[i].res == 64'd0));
      else passes++;
      checks++;
      if (alu_bus.overflow !== v[i].ov)
        $display("[TB] FAIL %s_ovf got=%b want=%b", v[i].name, alu_bus.overflow, v[i].ov);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_r;
    logic        exp_o;
    logic        exp_v;
    logic [3:0]  op;
    logic [63:0] a, b;
    logic        v;
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (alu_bus.data_out !== exp_r)
          $display("[TB] FAIL b2b_data[%0d] got=%h want=%h", i, alu_bus.data_out, exp_r);
        else passes++;
        checks++;
        if (alu_bus.zero !== (exp_r == 64'd0))
          $display("[TB] FAIL b2b_zero[%0d] got=%b want=%b", i, alu_bus.zero, (exp_r == 64'd0));
        else passes++;
        checks++;
        if (alu_bus.overflow !== exp_o)
          $display("[TB] FAIL b2b_ovf[%0d] got=%b want=%b", i, alu_bus.overflow, exp_o);
        else passes++;
        checks++;
        if (alu_bus.valid_out !== exp_v)
          $display("[TB] FAIL b2b_valid[%0d] got=%b want=%b", i, alu_bus.valid_out, exp_v);
        else passes++;
      end
      if (i < 300) begin
        op = 4'($urandom_range(0, 15));
        a  = rand_operand();
        b  = rand_operand();
        v  = 1'($urandom_range(0, 1));
        drive(op, a, b, v);
        model(op, a, b, exp_r, exp_o);
        exp_v = v;
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    drive(4'b0010, 64'd10, 64'd20, 1'b1);
    @(negedge clk);
    checks++;
    if (alu_bus.data_out !== 64'd30)
      $display("[TB] FAIL mid_pre_data got=%h want=%h", alu_bus.data_out, 64'd30);
    else passes++;
    rst = 1'b1;
    drive(4'b0001, 64'd1, 64'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (alu_bus.data_out !== 64'd0)
      $display("[TB] FAIL mid_rst_data got=%h want=%h", alu_bus.data_out, 64'd0);
    else passes++;
    checks++;
    if (alu_bus.valid_out !== 1'b0)
      $display("[TB] FAIL mid_rst_valid got=%b want=0", alu_bus.valid_out);
    else passes++;
    checks++;
    if (alu_bus.zero !== 1'b1)
      $display("[TB] FAIL mid_rst_zero got=%b want=1", alu_bus.zero);
    else passes++;
    rst = 1'b0;
    drive(4'b0110, 64'd50, 64'd8, 1'b1);
    @(negedge clk);
    checks++;
    if (alu_bus.data_out !== 64'd42)
      $display("[TB] FAIL mid_post_data got=%h want=%h", alu_bus.data_out, 64'd42);
    else passes++;
    checks++;
    if (alu_bus.valid_out !== 1'b1)
      $display("[TB] FAIL mid_post_valid got=%b want=1", alu_bus.valid_out);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst    = 1'b1;
    drive(4'b0000, 64'd0, 64'd0, 1'b0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
